// File: rtl/minisrc_datapath.sv
// Mini SRC 32-bit datapath: register file, special registers, shared bus, ALU,
// RAM and branch-condition logic, all steered by externally supplied strobes.
module minisrc_datapath #(
  parameter int MEM_DEPTH     = 512,
  parameter     MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        clr,
  output logic [15:0] RX_in,
  output logic [15:0] RX_out,
  input  logic [15:0] RX_in_man,
  input  logic [15:0] RX_out_man,
  input  logic        PC_in,
  input  logic        IR_in,
  input  logic        Y_in,
  input  logic        Z_in,
  input  logic        HI_in,
  input  logic        LO_in,
  input  logic        MAR_in,
  input  logic        MDR_in,
  input  logic        OutPort_in,
  input  logic        IncPC,
  input  logic        PC_out,
  input  logic        Zhigh_out,
  input  logic        Zlow_out,
  input  logic        HI_out,
  input  logic        LO_out,
  input  logic        MDR_out,
  input  logic        InPort_out,
  input  logic        C_out,
  input  logic        Read,
  input  logic        Write,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic [4:0]  alu_instruction_bits,
  input  logic [31:0] InPort_Data_In,
  output logic [31:0] Outport_Data_Out,
  output logic        CON_out,
  output logic [31:0] Bus_Data,
  output logic [31:0] ALUHigh_Data,
  output logic [31:0] ALULow_Data,
  output logic [31:0] R0_Data,
  output logic [31:0] R1_Data,
  output logic [31:0] R2_Data,
  output logic [31:0] R3_Data,
  output logic [31:0] R4_Data,
  output logic [31:0] R5_Data,
  output logic [31:0] R6_Data,
  output logic [31:0] R7_Data,
  output logic [31:0] R8_Data,
  output logic [31:0] R9_Data,
  output logic [31:0] R10_Data,
  output logic [31:0] R11_Data,
  output logic [31:0] R12_Data,
  output logic [31:0] R13_Data,
  output logic [31:0] R14_Data,
  output logic [31:0] R15_Data,
  output logic [31:0] PC_Data,
  output logic [31:0] IR_Data,
  output logic [31:0] Y_Data,
  output logic [31:0] Zhigh_Data,
  output logic [31:0] Zlow_Data,
  output logic [31:0] HI_Data,
  output logic [31:0] LO_Data,
  output logic [31:0] MAR_Data,
  output logic [31:0] MDR_Data,
  output logic [31:0] InPort_Data,
  output logic [31:0] C_sign_extended_Data,
  output logic [31:0] Mdatain
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [31:0] r [16];
  logic [31:0] pc, ir, y, zhi, zlo, hi, lo, mar, mdr, inport, outport;
  logic [31:0] bus, c_sext, alu_high, alu_low;
  logic [63:0] product;
  logic [4:0]  sh;
  logic [3:0]  sel_idx;
  logic [15:0] sel_onehot;
  logic        ba_zero;
  logic [31:0] mem [MEM_DEPTH];

  // Select/encode: the enabled IR register fields are ORed into one index.
  assign sel_idx    = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign sel_onehot = 16'h0001 << sel_idx;
  assign RX_in      = RX_in_man  | ({16{Rin}} & sel_onehot);
  assign RX_out     = RX_out_man | ({16{Rout | BAout}} & sel_onehot);
  assign ba_zero    = BAout && (sel_idx == 4'd0);

  assign c_sext  = {{13{ir[18]}}, ir[18:0]};
  assign Mdatain = mem[mar[AW-1:0]];

  // Lowest-priority driver is applied first so later (higher-priority) ones win.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
    bus = '0;
    if (C_out)      bus = c_sext;
    if (InPort_out) bus = inport;
    if (MDR_out)    bus = mdr;
    if (LO_out)     bus = lo;
    if (HI_out)     bus = hi;
    if (Zlow_out)   bus = zlo;
    if (Zhigh_out)  bus = zhi;
    if (PC_out)     bus = pc;
    for (int i = 15; i >= 0; i--) begin
      if (RX_out[i]) bus = (i == 0 && ba_zero) ? '0 : r[i];
    end
  end

  assign sh      = bus[4:0];
  assign product = {{32{y[31]}}, y} * {{32{bus[31]}}, bus};

  always_comb begin
    alu_low  = y + bus;
    alu_high = '0;
    if (IncPC) begin
      alu_low = bus + 32'd1;
    end else begin
      case (alu_instruction_bits)
        OP_ADD, OP_ADDI: alu_low = y + bus;
        OP_SUB:          alu_low = y - bus;
        OP_AND, OP_ANDI: alu_low = y & bus;
        OP_OR, OP_ORI:   alu_low = y | bus;
        OP_NOT:          alu_low = ~bus;
        OP_ROR:          alu_low = (y >> sh) | (y << (6'd32 - {1'b0, sh}));
        OP_ROL:          alu_low = (y << sh) | (y >> (6'd32 - {1'b0, sh}));
        OP_SHR:          alu_low = y >> sh;
        OP_SHRA:         alu_low = $signed(y) >>> sh;
        OP_SHL:          alu_low = y << sh;
        OP_MUL:          {alu_high, alu_low} = product;
        OP_DIV: begin
          if (bus != '0) begin
            alu_low  = $signed(y) / $signed(bus);
            alu_high = $signed(y) % $signed(bus);
          end else begin
            alu_low = '0;
          end
        end
        OP_NEG:          alu_low = '0 - bus;
        default:         alu_low = y + bus;
      endcase
    end
  end

  always_comb begin
    case (ir[20:19])
      2'b00:   CON_out = (bus == '0);
      2'b01:   CON_out = (bus != '0);
      2'b10:   CON_out = ~bus[31];
      default: CON_out = bus[31];
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      pc      <= '0;
      ir      <= '0;
      y       <= '0;
      zhi     <= '0;
      zlo     <= '0;
      hi      <= '0;
      lo      <= '0;
      mar     <= '0;
      mdr     <= '0;
      inport  <= '0;
      outport <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < 16; i++) begin
        if (RX_in[i]) r[i] <= bus;
      end
      if (PC_in)      pc      <= bus;
      if (IR_in)      ir      <= bus;
      if (Y_in)       y       <= bus;
      if (HI_in)      hi      <= bus;
      if (LO_in)      lo      <= bus;
      if (MAR_in)     mar     <= bus;
      if (OutPort_in) outport <= bus;
      if (MDR_in)     mdr     <= Read ? Mdatain : bus;
      if (Z_in) begin
        zhi <= alu_high;
        zlo <= alu_low;
      end
      inport <= InPort_Data_In;
    end
  end

  // NOTE: RAM has no reset; clr must leave stored program and data intact.
  always_ff @(posedge clk) begin
    if (Write) mem[mar[AW-1:0]] <= mdr;
  end

  assign Outport_Data_Out     = outport;
  assign Bus_Data             = bus;
  assign ALUHigh_Data         = alu_high;
  assign ALULow_Data          = alu_low;
  assign R0_Data              = r[0];
  assign R1_Data              = r[1];
  assign R2_Data              = r[2];
  assign R3_Data              = r[3];
  assign R4_Data              = r[4];
  assign R5_Data              = r[5];
  assign R6_Data              = r[6];
  assign R7_Data              = r[7];
  assign R8_Data              = r[8];
  assign R9_Data              = r[9];
  assign R10_Data             = r[10];
  assign R11_Data             = r[11];
  assign R12_Data             = r[12];
  assign R13_Data             = r[13];
  assign R14_Data             = r[14];
  assign R15_Data             = r[15];
  assign PC_Data              = pc;
  assign IR_Data              = ir;
  assign Y_Data               = y;
  assign Zhigh_Data           = zhi;
  assign Zlow_Data            = zlo;
  assign HI_Data              = hi;
  assign LO_Data              = lo;
  assign MAR_Data             = mar;
  assign MDR_Data             = mdr;
  assign InPort_Data          = inport;
  assign C_sign_extended_Data = c_sext;

endmodule

// File: tb/tb_minisrc_datapath.sv
// Directed and randomized checks of minisrc_datapath against a behavioural
// model of the register file, RAM writes and ALU arithmetic.
module tb_minisrc_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] RX_in, RX_out, RX_in_man, RX_out_man;
  logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
  logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
  logic        Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  alu_instruction_bits;
  logic [31:0] InPort_Data_In, Outport_Data_Out;
  logic        CON_out;
  logic [31:0] Bus_Data, ALUHigh_Data, ALULow_Data;
  logic [31:0] R0_Data, R1_Data, R2_Data, R3_Data, R4_Data, R5_Data, R6_Data, R7_Data;
  logic [31:0] R8_Data, R9_Data, R10_Data, R11_Data, R12_Data, R13_Data, R14_Data, R15_Data;
  logic [31:0] PC_Data, IR_Data, Y_Data, Zhigh_Data, Zlow_Data, HI_Data, LO_Data;
  logic [31:0] MAR_Data, MDR_Data, InPort_Data, C_sign_extended_Data, Mdatain;

  logic [31:0] r_tap [16];
  logic [31:0] model_r [16];
  int n_compared   = 0;
  int n_mismatched = 0;

  minisrc_datapath dut (
    .clk(clk), .clr(clr), .RX_in(RX_in), .RX_out(RX_out),
    .RX_in_man(RX_in_man), .RX_out_man(RX_out_man),
    .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC),
    .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
    .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
    .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .alu_instruction_bits(alu_instruction_bits),
    .InPort_Data_In(InPort_Data_In), .Outport_Data_Out(Outport_Data_Out), .CON_out(CON_out),
    .Bus_Data(Bus_Data), .ALUHigh_Data(ALUHigh_Data), .ALULow_Data(ALULow_Data),
    .R0_Data(R0_Data), .R1_Data(R1_Data), .R2_Data(R2_Data), .R3_Data(R3_Data),
    .R4_Data(R4_Data), .R5_Data(R5_Data), .R6_Data(R6_Data), .R7_Data(R7_Data),
    .R8_Data(R8_Data), .R9_Data(R9_Data), .R10_Data(R10_Data), .R11_Data(R11_Data),
    .R12_Data(R12_Data), .R13_Data(R13_Data), .R14_Data(R14_Data), .R15_Data(R15_Data),
    .PC_Data(PC_Data), .IR_Data(IR_Data), .Y_Data(Y_Data), .Zhigh_Data(Zhigh_Data),
    .Zlow_Data(Zlow_Data), .HI_Data(HI_Data), .LO_Data(LO_Data), .MAR_Data(MAR_Data),
    .MDR_Data(MDR_Data), .InPort_Data(InPort_Data),
    .C_sign_extended_Data(C_sign_extended_Data), .Mdatain(Mdatain)
  );

  assign r_tap[0]  = R0_Data;   assign r_tap[1]  = R1_Data;
  assign r_tap[2]  = R2_Data;   assign r_tap[3]  = R3_Data;
  assign r_tap[4]  = R4_Data;   assign r_tap[5]  = R5_Data;
  assign r_tap[6]  = R6_Data;   assign r_tap[7]  = R7_Data;
  assign r_tap[8]  = R8_Data;   assign r_tap[9]  = R9_Data;
  assign r_tap[10] = R10_Data;  assign r_tap[11] = R11_Data;
  assign r_tap[12] = R12_Data;  assign r_tap[13] = R13_Data;
  assign r_tap[14] = R14_Data;  assign r_tap[15] = R15_Data;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RX_in_man = '0; RX_out_man = '0;
    {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC} = '0;
    {PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out} = '0;
    {Read, Write, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    alu_instruction_bits = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // InPort samples its pin every edge, so one edge makes the value drivable.
  task automatic load_inport(input logic [31:0] v);
    InPort_Data_In = v;
    tick();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] v);
    load_inport(v);
    InPort_out = 1'b1; RX_in_man = 16'(1 << idx);
    tick(); idle();
    model_r[idx] = v;
  endtask

  task automatic load_y(input logic [31:0] v);
    load_inport(v); InPort_out = 1'b1; Y_in = 1'b1; tick(); idle();
  endtask

  task automatic set_ir(input logic [31:0] v);
    load_inport(v); InPort_out = 1'b1; IR_in = 1'b1; tick(); idle();
  endtask

  task automatic set_mar(input logic [31:0] v);
    load_inport(v); InPort_out = 1'b1; MAR_in = 1'b1; tick(); idle();
  endtask

  task automatic set_mdr(input logic [31:0] v);
    load_inport(v); InPort_out = 1'b1; MDR_in = 1'b1; tick(); idle();
  endtask

  task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    load_y(a);
    load_inport(b);
    InPort_out = 1'b1; alu_instruction_bits = op; Z_in = 1'b1;
    tick(); idle();
  endtask

  task automatic check_all_zero(input string pfx);
    for (int i = 0; i < 16; i++) check($sformatf("%s r%0d", pfx, i), r_tap[i], 32'h0);
    check({pfx, " pc"}, PC_Data, 32'h0);
    check({pfx, " ir"}, IR_Data, 32'h0);
    check({pfx, " y"}, Y_Data, 32'h0);
    check({pfx, " zhigh"}, Zhigh_Data, 32'h0);
    check({pfx, " zlow"}, Zlow_Data, 32'h0);
    check({pfx, " hi"}, HI_Data, 32'h0);
    check({pfx, " lo"}, LO_Data, 32'h0);
    check({pfx, " mar"}, MAR_Data, 32'h0);
    check({pfx, " mdr"}, MDR_Data, 32'h0);
    check({pfx, " inport"}, InPort_Data, 32'h0);
    check({pfx, " outport"}, Outport_Data_Out, 32'h0);
  endtask

  // Reference ALU from the arithmetic rules: signed 64-bit math, bitwise rotation loops.
  function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, p;
    logic [31:0] lo, hi;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    case (op)
      5'd4:        lo = a - b;
      5'd5, 5'd13: lo = a & b;
      5'd6, 5'd14: lo = a | b;
      5'd18:       lo = ~b;
      5'd7: begin lo = a; repeat (b[4:0]) lo = {lo[0], lo[31:1]}; end
      5'd8: begin lo = a; repeat (b[4:0]) lo = {lo[30:0], lo[31]}; end
      5'd9:        lo = a / (32'd1 << b[4:0]);
      5'd10:       lo = 32'(sa >>> b[4:0]);
      5'd11:       lo = a * (32'd1 << b[4:0]);
      5'd15: begin p = sa * sb; lo = p[31:0]; hi = p[63:32]; end
      5'd16: begin
        if (b != 0) begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
        else lo = '0;
      end
      5'd17:       lo = 32'(-sb);
      default:     lo = a + b;
    endcase
    return {hi, lo};
  endfunction

  logic [4:0]  ops [18] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                            5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd0, 5'd31};
  logic [63:0] exp64;
  logic [31:0] ra, rb;
  logic [4:0]  op;
  int          idx, jdx;

  initial begin
    idle();
    clr = 1'b1;
    InPort_Data_In = '0;
    for (int i = 0; i < 16; i++) model_r[i] = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    check_all_zero("startup");

    // Program word 0 through the datapath, then dirty every register.
    set_mar(32'h0);
    set_mdr(32'hA100_0000);
    Write = 1'b1; tick(); idle();
    check("ram0 written", Mdatain, 32'hA100_0000);
    load_reg(2, 32'h55);
    load_reg(9, 32'h99);
    load_y(32'h77);
    load_inport(32'h33);
    InPort_out = 1'b1;
    {PC_in, IR_in, HI_in, LO_in, OutPort_in, Z_in, MDR_in, MAR_in} = '1;
    tick(); idle();
    check("pre-clr pc", PC_Data, 32'h33);
    check("pre-clr zlow", Zlow_Data, 32'hAA);

    // Mid-cycle asynchronous clear.
    InPort_Data_In = '0;
    #3 clr = 1'b1;
    #1 check_all_zero("midclr");
    check("midclr ram kept", Mdatain, 32'hA100_0000);
    #1 clr = 1'b0;
    for (int i = 0; i < 16; i++) model_r[i] = '0;

    // Preload R2 with two held edges.
    InPort_Data_In = 32'hFF; InPort_out = 1'b1; RX_in_man = 16'h0004;
    tick(); tick(); idle();
    model_r[2] = 32'hFF;
    check("preload r2", R2_Data, 32'hFF);

    // Fetch from PC=0.
    PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
    tick(); idle();
    check("fetch1 mar", MAR_Data, 32'h0);
    check("fetch1 zlow", Zlow_Data, 32'h1);
    check("fetch1 zhigh", Zhigh_Data, 32'h0);
    Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1;
    tick(); idle();
    check("fetch2 pc", PC_Data, 32'h1);
    check("fetch2 mdr", MDR_Data, 32'hA100_0000);
    MDR_out = 1'b1; IR_in = 1'b1;
    tick(); idle();
    check("fetch3 ir", IR_Data, 32'hA100_0000);

    // jr R2.
    Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1;
    #1;
    check("jr rx_out", {16'h0, RX_out}, 32'h0000_0004);
    check("jr bus", Bus_Data, 32'hFF);
    tick(); idle();
    check("jr pc", PC_Data, 32'hFF);

    // Directed ALU cases.
    alu_run(32'd7, 32'hFFFF_FFFD, 5'b01111);
    check("mul zhigh", Zhigh_Data, 32'hFFFF_FFFF);
    check("mul zlow", Zlow_Data, 32'hFFFF_FFEB);
    alu_run(32'd7, 32'hFFFF_FFFD, 5'b10000);
    check("div zlow", Zlow_Data, 32'hFFFF_FFFE);
    check("div zhigh", Zhigh_Data, 32'h1);
    Zhigh_out = 1'b1; HI_in = 1'b1; tick(); idle();
    check("hi load", HI_Data, 32'h1);
    HI_out = 1'b1; OutPort_in = 1'b1; tick(); idle();
    check("outport load", Outport_Data_Out, 32'h1);
    alu_run(32'd1, 32'd1, 5'b00111);
    check("ror zlow", Zlow_Data, 32'h8000_0000);
    alu_run(32'd5, 32'd0, 5'b10000);
    check("div0 zlow", Zlow_Data, 32'h0);
    check("div0 zhigh", Zhigh_Data, 32'h0);
    alu_run(32'h8000_0000 >> 1, 32'd0, 5'b00111);
    check("ror by 0", Zlow_Data, 32'h4000_0000);
    Zlow_out = 1'b1; LO_in = 1'b1; tick(); idle();
    check("lo load", LO_Data, 32'h4000_0000);
    LO_out = 1'b1; MDR_out = 1'b1;
    #1 check("prio lo over mdr", Bus_Data, 32'h4000_0000);
    idle();

    // Branch condition.
    set_ir(32'h0008_0000);
    #1 check("con ne bus0", {31'h0, CON_out}, 32'h0);
    check("bus undriven", Bus_Data, 32'h0);
    InPort_out = 1'b1;
    #1 check("con ne bus!=0", {31'h0, CON_out}, 32'h1);
    idle();
    set_ir(32'h0018_0000);
    load_inport(32'h8000_0000);
    InPort_out = 1'b1;
    #1 check("con neg", {31'h0, CON_out}, 32'h1);
    idle();
    #1 check("con neg bus0", {31'h0, CON_out}, 32'h0);

    // Sign extension of the constant field.
    set_ir(32'h0007_FFF0);
    C_out = 1'b1;
    #1 check("c sext neg", Bus_Data, 32'hFFFF_FFF0);
    idle();
    set_ir(32'h0003_1234);
    check("c sext pos", C_sign_extended_Data, 32'h0003_1234);

    // Select/encode: Ra=3, Rb=5, Rc=9.
    set_ir((32'd3 << 23) | (32'd5 << 19) | (32'd9 << 15));
    Gra = 1'b1; Rin = 1'b1;
    #1 check("rin ra", {16'h0, RX_in}, 32'h0008);
    idle(); Grc = 1'b1; Rin = 1'b1;
    #1 check("rin rc", {16'h0, RX_in}, 32'h0200);
    idle(); Gra = 1'b1; Grb = 1'b1; Rin = 1'b1; RX_in_man = 16'h0001;
    #1 check("rin ra|rb + man", {16'h0, RX_in}, 32'h0081);
    idle(); Grb = 1'b1; Rout = 1'b1; RX_out_man = 16'h8000;
    #1 check("rout rb + man", {16'h0, RX_out}, 32'h8020);
    idle();

    // BAout with Rb = 0 drives zero in place of R0.
    load_reg(0, 32'hDEAD_BEEF);
    set_ir(32'h0);
    Grb = 1'b1; BAout = 1'b1;
    #1 check("baout rx_out", {16'h0, RX_out}, 32'h0001);
    check("baout bus", Bus_Data, 32'h0);
    idle(); Grb = 1'b1; Rout = 1'b1;
    #1 check("rout r0 bus", Bus_Data, 32'hDEAD_BEEF);
    idle(); RX_out_man = 16'h0001; PC_out = 1'b1;
    #1 check("prio r0 over pc", Bus_Data, 32'hDEAD_BEEF);
    idle();

    // Store to word 5; word 0 must be untouched.
    set_mar(32'd5);
    set_mdr(32'h1234);
    Write = 1'b1; tick(); idle();
    check("store mdatain", Mdatain, 32'h1234);
    set_mar(32'd0);
    check("ram0 intact", Mdatain, 32'hA100_0000);

    // Randomized register-file traffic against the model.
    for (int k = 0; k < 16; k++) begin
      idx = $urandom_range(0, 15);
      load_reg(idx, $urandom);
      jdx = $urandom_range(0, 15);
      RX_out_man = 16'(1 << jdx);
      #1 check($sformatf("rand read r%0d", jdx), Bus_Data, model_r[jdx]);
      idle();
    end
    for (int i = 0; i < 16; i++) check($sformatf("final r%0d", i), r_tap[i], model_r[i]);

    // Randomized ALU operations against the model.
    for (int k = 0; k < 48; k++) begin
      op = ops[$urandom_range(0, 17)];
      ra = $urandom;
      rb = $urandom;
      if (ra == 32'h8000_0000) ra = 32'd1;
      if (op inside {5'd7, 5'd8, 5'd9, 5'd10, 5'd11}) rb = $urandom_range(0, 31);
      else if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 3);
      alu_run(ra, rb, op);
      exp64 = model_alu(op, ra, rb);
      check($sformatf("alu op%0d zlow", op), Zlow_Data, exp64[31:0]);
      check($sformatf("alu op%0d zhigh", op), Zhigh_Data, exp64[63:32]);
    end

    // IncPC overrides whatever op is selected.
    for (int k = 0; k < 4; k++) begin
      ra = $urandom_range(0, 1000);
      rb = $urandom;
      load_y(ra);
      load_inport(rb);
      InPort_out = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
      alu_instruction_bits = ops[$urandom_range(0, 17)];
      tick(); idle();
      check("incpc zlow", Zlow_Data, rb + 32'd1);
      check("incpc zhigh", Zhigh_Data, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
